tdo_word_arbiter: RTL and testbench

Round-robin scheduler that shares one serial TDO output among `NUM_REQ` requesters, each presenting a `WIDTH`-bit word. It sits between the TAP controller and the data-register sources (IDCODE, status, user registers). It grants one requester, latches its word, and shifts the word out MSB-first, one bit per `shift_en` cycle. It then acknowledges completion and rotates priority.

---
 rtl/jtag_pkg.sv | 13 +
 rtl/word_serializer.sv | 57 +++++
 rtl/tdo_word_arbiter.sv | 144 ++++++++++++++
 tb/tb_tdo_word_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared types for the TDO word arbiter: transfer FSM states and the default word width.
package jtag_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/word_serializer.sv
// Load/shift/pause shift register with a bit counter and a falling-edge TDO register.
module word_serializer
   import jtag_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic             tdo_en_i,
   input  logic [WIDTH-1:0] word_i,
   output logic             last_o,
   output logic             tdo_o
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             tdo_q;

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (load_i) begin
         sr_d  = word_i;
         cnt_d = CW'(WIDTH);
      end else if (shift_i && (cnt_q != '0)) begin
         sr_d  = {sr_q[WIDTH-2:0], 1'b0};
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   // Launching on the falling edge gives the TAP a half cycle of hold margin.
   always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tdo_q <= 1'b0;
      end else begin
         tdo_q <= tdo_en_i ? sr_q[WIDTH-1] : 1'b0;
      end
   end

   // One bit left: the next accepted shift completes the word.
   assign last_o = (cnt_q == CW'(1));
   assign tdo_o  = tdo_q;

endmodule

// File: rtl/tdo_word_arbiter.sv
// Round-robin owner of the shared TDO line: grants one requester, serialises its
// word MSB-first, then acks the owner and rotates priority past it.
module tdo_word_arbiter
   import jtag_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = DEFAULT_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] data,
   input  logic                     shift_en,
   input  logic                     abort,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       ack,
   output logic                     busy,
   output logic                     tdo,
   output state_e                   dbg_state
);
   localparam int unsigned IW = $clog2(NUM_REQ);

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [IW-1:0]      owner_q, owner_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [IW-1:0]      pick, cidx, next_ptr;
   logic               found;
   logic               load, shift, last, tdo_en;
   logic [WIDTH-1:0]   words [NUM_REQ];
   logic [WIDTH-1:0]   load_word;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
      assign words[g] = data[g*WIDTH +: WIDTH];
   end

   assign load_word = words[owner_q];

   // ptr_q is the highest-priority index, i.e. one past the last owner.
   always_comb begin
      pick  = ptr_q;
      found = 1'b0;
      cidx  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cidx = IW'((32'(ptr_q) + i) % NUM_REQ);
         if (!found && req[cidx]) begin
            pick  = cidx;
            found = 1'b1;
         end
      end
   end

   assign next_ptr = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ack_d   = '0;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      load    = 1'b0;
      shift   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (found) begin
               grant_d       = '0;
               grant_d[pick] = 1'b1;
               owner_d       = pick;
               state_d       = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               grant_d = '0;
               ptr_d   = next_ptr;
               state_d = ST_IDLE;
            end else begin
               load    = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // Abort outranks the final shift; an aborted owner still loses priority.
            if (abort) begin
               grant_d = '0;
               ptr_d   = next_ptr;
               state_d = ST_IDLE;
            end else begin
               shift = shift_en;
               if (shift_en && last) begin
                  ack_d   = grant_q;
                  grant_d = '0;
                  ptr_d   = next_ptr;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ack_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   assign tdo_en = (state_q == ST_SHIFT);

   word_serializer #(
      .WIDTH (WIDTH)
   ) u_ser (
      .clk      (clk),
      .reset_n  (reset_n),
      .load_i   (load),
      .shift_i  (shift),
      .tdo_en_i (tdo_en),
      .word_i   (load_word),
      .last_o   (last),
      .tdo_o    (tdo)
   );

   assign grant     = grant_q;
   assign ack       = ack_q;
   assign busy      = (state_q != ST_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_tdo_word_arbiter.sv
// Randomised bench for tdo_word_arbiter: driver tasks push expected transfers,
// a monitor pops them on ack/abort and checks owner and serial word.
module tb_tdo_word_arbiter;
   import jtag_pkg::*;

   localparam int NUM_REQ       = 4;
   localparam int WIDTH         = 32;
   localparam int EW            = WIDTH + 4;
   localparam int NO_ABORT      = -2;
   localparam int ABORT_IN_LOAD = -1;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] data;
   logic                     shift_en;
   logic                     abort;
   logic [NUM_REQ-1:0]       grant;
   logic [NUM_REQ-1:0]       ack;
   logic                     busy;
   logic                     tdo;
   state_e                   dbg_state;

   int total = 0;
   int bad   = 0;
   logic [EW-1:0] exp_q[$];
   int model_last = NUM_REQ - 1;

   tdo_word_arbiter #(
      .NUM_REQ (NUM_REQ),
      .WIDTH   (WIDTH)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .data      (data),
      .shift_en  (shift_en),
      .abort     (abort),
      .grant     (grant),
      .ack       (ack),
      .busy      (busy),
      .tdo       (tdo),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #(60000 * 10);
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [NUM_REQ-1:0] onehot(input int idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Reference arbitration: first set request searching upward from last owner + 1.
   function automatic int model_pick(input logic [NUM_REQ-1:0] rv);
      int c;
      for (int i = 1; i <= NUM_REQ; i++) begin
         c = (model_last + i) % NUM_REQ;
         if (rv[c]) return c;
      end
      return -1;
   endfunction

   // ---------------- driver ----------------
   task automatic run_txn(input logic [NUM_REQ-1:0] rv, input int abort_at, input int pause_at,
                          input int pause_len, input int en_pct, input bit wild,
                          input bit use_fixed, input logic [WIDTH-1:0] fixed_word);
      logic [WIDTH-1:0] words [NUM_REQ];
      int win, bits, cyc, pauses, edges;
      bit done, aborted, ab, en, in_shift;
      for (int i = 0; i < NUM_REQ; i++) begin
         words[i] = use_fixed ? fixed_word : WIDTH'($urandom);
         data[i*WIDTH +: WIDTH] = words[i];
      end
      win = model_pick(rv);
      model_last = win;
      exp_q.push_back({(abort_at != NO_ABORT), 3'(win), words[win]});
      req      = rv;
      abort    = 1'b0;
      shift_en = 1'b0;
      edges    = 0;
      while (grant == '0 && edges < 6) begin
         @(posedge clk); #1;
         edges++;
      end
      if (grant == '0) begin
         chk("grant_timeout", 0, 1);
         req = '0;
         return;
      end
      chk("busy_high", busy, 1);
      bits = 0; cyc = 0; pauses = 0; done = 0; aborted = 0;
      while (!done && cyc < 3*WIDTH + pause_len + 10) begin
         in_shift = (cyc > 0);
         ab = in_shift ? (abort_at == bits) : (abort_at == ABORT_IN_LOAD);
         if (in_shift && bits == pause_at && pauses < pause_len) begin
            en = 1'b0;
            pauses++;
         end else begin
            en = ($urandom_range(0, 99) < en_pct);
         end
         shift_en = en;
         abort    = ab;
         if (wild && in_shift) begin
            req = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++) data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         end
         @(negedge clk); #1;
         if (in_shift) chk("tdo_bit", tdo, words[win][WIDTH-1-bits]);
         else          chk("tdo_load_zero", tdo, 0);
         @(posedge clk); #1;
         cyc++;
         if (ab) begin
            aborted = 1'b1;
            done    = 1'b1;
         end else if (in_shift && en) begin
            bits++;
            done = (bits == WIDTH);
         end
      end
      shift_en = 1'b0;
      abort    = 1'b0;
      req      = '0;
      if (!done) begin
         chk("txn_timeout", 0, 1);
         return;
      end
      if (aborted) begin
         chk("abort_no_ack", ack, 0);
         chk("abort_grant_clr", grant, 0);
         chk("abort_busy_clr", busy, 0);
         chk("abort_state_idle", dbg_state, ST_IDLE);
         @(negedge clk); #1;
         chk("abort_tdo_zero", tdo, 0);
      end else begin
         chk("done_ack", ack, onehot(win));
         chk("done_grant_clr", grant, 0);
         chk("done_busy", busy, 1);
         if (en_pct == 100) chk("ack_latency", cyc, WIDTH + 1 + pause_len);
         @(posedge clk); #1;
         chk("ack_one_cycle", ack, 0);
         chk("idle_busy_low", busy, 0);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [WIDTH-1:0]   col        = '0;
   logic [NUM_REQ-1:0] prev_grant = '0;

   always @(negedge clk) begin
      logic [EW-1:0] e;
      #4;
      if (!reset_n) begin
         col        = '0;
         prev_grant = '0;
      end else begin
         if (shift_en && grant != '0) col = {col[WIDTH-2:0], tdo};
         if (ack != '0) begin
            if (exp_q.size() == 0) chk("ack_unexpected", ack, 0);
            else begin
               e = exp_q.pop_front();
               chk("ack_not_aborted", e[EW-1], 0);
               chk("ack_owner", ack, onehot(e[EW-2 -: 3]));
               chk("word_bits", col, e[WIDTH-1:0]);
            end
         end else if (prev_grant != '0 && grant == '0) begin
            if (exp_q.size() == 0) chk("abort_unexpected", prev_grant, 0);
            else begin
               e = exp_q.pop_front();
               chk("abort_expected", e[EW-1], 1);
            end
         end
         if (prev_grant == '0 && grant != '0 && exp_q.size() != 0)
            chk("grant_order", grant, onehot(exp_q[0][EW-2 -: 3]));
         if (grant == '0) chk("tdo_idle_zero", tdo, 0);
         prev_grant = grant;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [NUM_REQ-1:0] rv;
      int ab, r, edges;
      req = '0; data = '0; shift_en = 1'b0; abort = 1'b0; reset_n = 1'b0;
      #2;
      chk("rst_grant", grant, 0);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tdo", tdo, 0);
      chk("rst_state", dbg_state, ST_IDLE);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // round robin with all requesters asserted
      for (int t = 0; t < 5; t++) run_txn(4'b1111, NO_ABORT, -1, 0, 100, 0, 0, '0);
      // single request, fixed word
      run_txn(4'b0001, NO_ABORT, -1, 0, 100, 0, 1, 32'hDEADBEEF);
      // pause of 5 cycles after bit 20
      run_txn(4'b0001, NO_ABORT, 20, 5, 100, 0, 0, '0);
      // abort requester 2 after 10 bits, then 1 wins via wrap
      run_txn(4'b0010, NO_ABORT, -1, 0, 100, 0, 0, '0);
      run_txn(4'b0110, 10, -1, 0, 100, 0, 0, '0);
      run_txn(4'b0110, NO_ABORT, -1, 0, 100, 0, 0, '0);
      // abort in LOAD, abort on the final shift edge
      run_txn(4'b1000, ABORT_IN_LOAD, -1, 0, 100, 0, 0, '0);
      run_txn(4'b0100, WIDTH - 1, -1, 0, 100, 0, 0, '0);

      // asynchronous reset in the middle of a word
      run_txn(4'b0001, NO_ABORT, -1, 0, 100, 0, 0, '0);
      data = '1; req = 4'b0010; shift_en = 1'b1;
      edges = 0;
      while (grant == '0 && edges < 6) begin
         @(posedge clk); #1;
         edges++;
      end
      chk("rst_mid_grant", grant, 4'b0010);
      repeat (16) @(posedge clk);
      @(negedge clk); #2;
      chk("rst_mid_tdo_before", tdo, 1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_grant_clr", grant, 0);
      chk("rst_mid_busy_clr", busy, 0);
      chk("rst_mid_tdo_clr", tdo, 0);
      chk("rst_mid_ack_clr", ack, 0);
      req = '0; shift_en = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      model_last = NUM_REQ - 1;
      run_txn(4'b1001, NO_ABORT, -1, 0, 100, 0, 0, '0);

      // randomised traffic
      for (int t = 0; t < 40; t++) begin
         rv = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
         r  = $urandom_range(0, 9);
         ab = (r == 0) ? ABORT_IN_LOAD : (r < 3) ? $urandom_range(0, WIDTH - 1) : NO_ABORT;
         run_txn(rv, ab, -1, 0, 75, 1, 0, '0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      repeat (4) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
